id_exe_skid_stage: RTL and testbench

//  Elastic ID->EXE pipeline register: payload fields from decode are captured and

---
 rtl/id_exe_skid_stage.sv | 115 +++++++++++
 tb/tb_id_exe_skid_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_skid_stage.sv
// ID->EXE elastic pipeline register with a main entry and a skid entry; optional stall counter under IDEX_STALL_CNT_EN.
// Latency: 1 cycle input->output when main is empty; sustains 1 beat/cycle while out_ready=1.
// Backpressure: in_ready is !skid_valid (no path from out_ready); a beat arriving while main is held parks in skid.
module id_exe_skid_stage #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5,
    parameter int ISIZE = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] rdata1_in,
    input  logic [DSIZE-1:0] rdata2_in,
    input  logic [DSIZE-1:0] mux_in,
    input  logic [DSIZE-1:0] imm_in,
    input  logic [OPW-1:0]   opcode_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic [ISIZE-1:0] pc_in,
    input  logic [4:0]       ctrl_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] rdata1_out,
    output logic [DSIZE-1:0] rdata2_out,
    output logic [DSIZE-1:0] mux_out,
    output logic [DSIZE-1:0] imm_out,
    output logic [OPW-1:0]   opcode_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic [ISIZE-1:0] pc_out,
    output logic [4:0]       ctrl_out
`ifdef IDEX_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef struct packed {
        logic [DSIZE-1:0] rdata1;
        logic [DSIZE-1:0] rdata2;
        logic [DSIZE-1:0] mux;
        logic [DSIZE-1:0] imm;
        logic [OPW-1:0]   opcode;
        logic [ASIZE-1:0] waddr;
        logic [ISIZE-1:0] pc;
        logic [4:0]       ctrl;
    } payload_t;

    payload_t main_dat;
    payload_t skid_dat;
    payload_t in_dat;
    logic     main_valid;
    logic     skid_valid;
    logic     accept;
    logic     release_beat;

    assign in_dat = '{rdata1: rdata1_in, rdata2: rdata2_in, mux: mux_in, imm: imm_in,
                      opcode: opcode_in, waddr: waddr_in, pc: pc_in, ctrl: ctrl_in};

    // Ready depends only on registered skid occupancy, masked while reset is held.
    assign in_ready     = !skid_valid && !rst;
    assign accept       = in_valid && in_ready && !flush;
    assign release_beat = main_valid && out_ready;

    assign out_valid  = main_valid;
    assign rdata1_out = main_dat.rdata1;
    assign rdata2_out = main_dat.rdata2;
    assign mux_out    = main_dat.mux;
    assign imm_out    = main_dat.imm;
    assign opcode_out = main_dat.opcode;
    assign waddr_out  = main_dat.waddr;
    assign pc_out     = main_dat.pc;
    // A bubble must never write the register file, memory or redirect fetch.
    assign ctrl_out   = main_valid ? main_dat.ctrl : 5'b0;

    // Main/skid occupancy and payload: skid always drains into main before new input.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_dat   <= '0;
            skid_dat   <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || release_beat) begin
            if (skid_valid) begin
                main_dat   <= skid_dat;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_dat   <= in_dat;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_dat   <= in_dat;
            skid_valid <= 1'b1;
        end
    end

`ifdef IDEX_STALL_CNT_EN
    // Saturating count of cycles where execute refuses a valid beat; flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (main_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_exe_skid_stage.sv
// Bench for id_exe_skid_stage: directed vectors plus a queue scoreboard of accepted beats.
// Inputs change #1 after posedge; outputs and handshakes are sampled at negedge.
// Monitor checks every release against the queue and checks held payload stability.
module tb_id_exe_skid_stage;

    typedef struct packed {
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] mux;
        logic [31:0] imm;
        logic [2:0]  opcode;
        logic [4:0]  waddr;
        logic [31:0] pc;
        logic [4:0]  ctrl;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] rdata1_in, rdata2_in, mux_in, imm_in, pc_in;
    logic [2:0]  opcode_in;
    logic [4:0]  waddr_in, ctrl_in;
    logic [31:0] rdata1_out, rdata2_out, mux_out, imm_out, pc_out;
    logic [2:0]  opcode_out;
    logic [4:0]  waddr_out, ctrl_out;
`ifdef IDEX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int    nvec = 0;
    int    nerr = 0;
    beat_t exp_q[$];
    beat_t out_b;
    beat_t held_b;
    logic  held = 1'b0;

    always #5 clk = ~clk;

    id_exe_skid_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .mux_in(mux_in), .imm_in(imm_in),
        .opcode_in(opcode_in), .waddr_in(waddr_in), .pc_in(pc_in), .ctrl_in(ctrl_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .rdata1_out(rdata1_out), .rdata2_out(rdata2_out), .mux_out(mux_out), .imm_out(imm_out),
        .opcode_out(opcode_out), .waddr_out(waddr_out), .pc_out(pc_out), .ctrl_out(ctrl_out)
`ifdef IDEX_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    assign out_b = '{rdata1: rdata1_out, rdata2: rdata2_out, mux: mux_out, imm: imm_out,
                     opcode: opcode_out, waddr: waddr_out, pc: pc_out, ctrl: ctrl_out};

    // Payload fully determined by pc; ctrl is never zero so bubbles are distinguishable.
    function automatic beat_t mk(input logic [31:0] pc);
        beat_t b;
        b.rdata1 = pc * 3 + 1;
        b.rdata2 = ~pc;
        b.mux    = pc ^ 32'h5a5a_0f0f;
        b.imm    = pc << 2;
        b.opcode = pc[2:0];
        b.waddr  = pc[4:0] ^ 5'h15;
        b.pc     = pc;
        b.ctrl   = 5'((pc % 31) + 1);
        return b;
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic put(input logic vld, input logic [31:0] pc);
        beat_t b;
        b         = mk(pc);
        in_valid  = vld;
        rdata1_in = b.rdata1;
        rdata2_in = b.rdata2;
        mux_in    = b.mux;
        imm_in    = b.imm;
        opcode_in = b.opcode;
        waddr_in  = b.waddr;
        pc_in     = b.pc;
        ctrl_in   = b.ctrl;
    endtask

    // One clock: record an accepted beat as expected output, then advance past the edge.
    task automatic step();
        @(negedge clk);
        if (in_valid && in_ready && !flush && !rst)
            exp_q.push_back(mk(pc_in));
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every release in order, hold stability, bubble ctrl; drop on flush/reset.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                chk("held_valid", 256'(out_valid), 256'(1));
                chk("held_payload", 256'(out_b), 256'(held_b));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL release: got pc %0h expected no beat", pc_out);
                end else begin
                    chk("release_beat", 256'(out_b), 256'(exp_q.pop_front()));
                end
            end
            if (!out_valid)
                chk("bubble_ctrl", 256'(ctrl_out), 256'(0));
            held   = out_valid && !out_ready && !flush;
            held_b = out_b;
            if (flush)
                exp_q.delete();
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        put(1'b0, 32'h0);
        step(); step();
        // Reset state.
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_payload", 256'(out_b), 256'(0));
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 256'(in_ready), 256'(1));

        // Streaming: each beat appears one cycle after it is offered, no gaps.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put(1'b1, 32'(i));
            step();
            chk("stream_valid", 256'(out_valid), 256'(1));
            chk("stream_pc", 256'(pc_out), 256'(i));
        end
        put(1'b0, 32'h0);
        step();
        chk("stream_end_valid", 256'(out_valid), 256'(0));

        // Backpressure: second beat parks in skid, third refused, order kept.
        put(1'b1, 32'h10);
        step();
        out_ready = 1'b0;
        put(1'b1, 32'h14);
        step();
        chk("skid_in_ready", 256'(in_ready), 256'(0));
        chk("skid_main_pc", 256'(pc_out), 256'(32'h10));
        put(1'b1, 32'h18);
        step();
        chk("skid_hold_pc", 256'(pc_out), 256'(32'h10));
        put(1'b0, 32'h0);
        out_ready = 1'b1;
        step();
        chk("drain_pc", 256'(pc_out), 256'(32'h14));
        chk("drain_in_ready", 256'(in_ready), 256'(1));
        step();
        chk("drain_empty", 256'(out_valid), 256'(0));

        // Flush with both entries full and a beat offered.
        out_ready = 1'b0;
        put(1'b1, 32'h30); step();
        put(1'b1, 32'h34); step();
        chk("full_in_ready", 256'(in_ready), 256'(0));
        flush = 1'b1;
        put(1'b1, 32'h20); step();
        flush = 1'b0;
        put(1'b0, 32'h0);
        chk("flush_valid", 256'(out_valid), 256'(0));
        chk("flush_ctrl", 256'(ctrl_out), 256'(0));
        chk("flush_in_ready", 256'(in_ready), 256'(1));
        out_ready = 1'b1;
        step();
        chk("flush_no_resurrect", 256'(out_valid), 256'(0));

        // Flush while ready: the offered beat is dropped, not accepted.
        out_ready = 1'b0;
        put(1'b1, 32'h40); step();
        flush = 1'b1;
        put(1'b1, 32'h24); step();
        flush = 1'b0;
        put(1'b0, 32'h0);
        out_ready = 1'b1;
        chk("flush2_valid", 256'(out_valid), 256'(0));
        step();
        chk("flush2_dropped", 256'(out_valid), 256'(0));

        // Reset with two beats held.
        out_ready = 1'b0;
        put(1'b1, 32'h50); step();
        put(1'b1, 32'h54); step();
        rst = 1'b1;
        put(1'b0, 32'h0);
        #1;
        chk("midrst_in_ready", 256'(in_ready), 256'(0));
        step();
        chk("midrst_valid", 256'(out_valid), 256'(0));
        chk("midrst_payload", 256'(out_b), 256'(0));
        chk("midrst_in_ready2", 256'(in_ready), 256'(0));
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("midrst_release_ready", 256'(in_ready), 256'(1));
        chk("midrst_nothing", 256'(out_valid), 256'(0));

        // Random handshakes with occasional flush against the scoreboard.
        begin
            logic [31:0] npc;
            npc = 32'h100;
            for (int c = 0; c < 4000; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 59) == 0);
                put($urandom_range(0, 2) != 0, npc);
                @(negedge clk);
                if (in_valid && in_ready && !flush) begin
                    exp_q.push_back(mk(pc_in));
                    npc = npc + 32'd1;
                end
                @(posedge clk);
                #1;
            end
        end
        flush = 1'b0;
        put(1'b0, 32'h0);
        out_ready = 1'b1;
        repeat (4) step();
        chk("random_drained", 256'(exp_q.size()), 256'(0));

`ifdef IDEX_STALL_CNT_EN
        rst = 1'b1; step(); rst = 1'b0;
        chk("stall_rst", 256'(stall_cnt), 256'(0));
        out_ready = 1'b0;
        put(1'b1, 32'h60); step();
        put(1'b0, 32'h0);
        repeat (5) step();
        chk("stall_five", 256'(stall_cnt), 256'(5));
        repeat (70000) step();
        chk("stall_sat", 256'(stall_cnt), 256'(16'hFFFF));
        out_ready = 1'b1;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
